// File: rtl/ysyx_23060059_imem_responder.sv
// rtl/ysyx_23060059_imem_responder.sv - AXI4-Lite read responder with fixed latency and preload write port
module ysyx_23060059_imem_responder #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_mask
);
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN  = 32'd4 << DEPTH_LOG2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] mem [DEPTH];

    logic [31:0] rd_off;
    logic [31:0] wr_off;
    logic [31:0] cap_data;
    logic [1:0]  cap_resp;

    assign rd_off = addr_q - BASE;
    assign wr_off = wr_addr - BASE;

    // Out-of-window addresses take priority over misalignment.
    always_comb begin
        cap_data = 32'h0;
        cap_resp = RESP_OKAY;
        if (rd_off >= SPAN) begin
            cap_resp = RESP_DECERR;
        end else if (rd_off[1:0] != 2'b00) begin
            cap_resp = RESP_SLVERR;
        end else begin
            cap_data = mem[rd_off[DEPTH_LOG2+1:2]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= 32'h0;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= 32'h0;
            axi_rresp   <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    axi_arready <= 1'b1;
                    if (axi_arvalid && axi_arready) begin
                        addr_q      <= axi_araddr;
                        cnt         <= LAT;
                        axi_arready <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        axi_rvalid <= 1'b1;
                        axi_rdata  <= cap_data;
                        axi_rresp  <= cap_resp;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (axi_rready) begin
                        axi_rvalid  <= 1'b0;
                        axi_arready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Preload port runs regardless of FSM state; the array is never reset.
    always_ff @(posedge clock) begin
        if (wr_en && (wr_off < SPAN)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_off[DEPTH_LOG2+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060059_imem_responder.sv
// tb/tb_ysyx_23060059_imem_responder.sv - directed vector bench for the instruction memory responder
module tb_ysyx_23060059_imem_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic        sel;
    logic        arvalid;
    logic        rready;
    logic [31:0] araddr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;

    logic        arready_a, rvalid_a, arready_b, rvalid_b;
    logic [31:0] rdata_a, rdata_b;
    logic [1:0]  rresp_a, rresp_b;
    logic        arready_s, rvalid_s;
    logic [31:0] rdata_s;
    logic [1:0]  rresp_s;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;
    int last_hs  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign arready_s = sel ? arready_b : arready_a;
    assign rvalid_s  = sel ? rvalid_b  : rvalid_a;
    assign rdata_s   = sel ? rdata_b   : rdata_a;
    assign rresp_s   = sel ? rresp_b   : rresp_a;

    ysyx_23060059_imem_responder #(.LATENCY(2)) dut_a (
        .clock(clock), .reset(reset),
        .axi_arvalid(arvalid && !sel), .axi_arready(arready_a), .axi_araddr(araddr),
        .axi_rvalid(rvalid_a), .axi_rready(rready && !sel), .axi_rdata(rdata_a), .axi_rresp(rresp_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask)
    );

    ysyx_23060059_imem_responder #(.LATENCY(0)) dut_b (
        .clock(clock), .reset(reset),
        .axi_arvalid(arvalid && sel), .axi_arready(arready_b), .axi_araddr(araddr),
        .axi_rvalid(rvalid_b), .axi_rready(rready && sel), .axi_rdata(rdata_b), .axi_rresp(rresp_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic s, input logic [31:0] a, input logic [31:0] ed,
                           input logic [1:0] er, input string nm);
        int t;
        int n;
        int lat;
        sel = s;
        lat = s ? 0 : 2;
        arvalid = 1'b1;
        araddr  = a;
        t = 0;
        while (!arready_s && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk({nm, " arready"}, 64'(arready_s), 64'd1);
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        last_hs = cyc;
        n = 1;
        while (!rvalid_s && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat + 2));
        chk({nm, " rdata"}, 64'(rdata_s), 64'(ed));
        chk({nm, " rresp"}, 64'(rresp_s), 64'(er));
        @(negedge clock);
        chk({nm, " done"}, 64'({rvalid_s, arready_s}), 64'b01);
    endtask

    vec_t vecs[7];
    logic [31:0] expb[4];
    int hs[4];
    int seen;

    initial begin
        vecs[0] = '{32'h8000_0000, 32'hDEAD_BEEF, 2'b00, "word0"};
        vecs[1] = '{32'h8000_0004, 32'h11BB_33DD, 2'b00, "masked"};
        vecs[2] = '{32'h8000_1000, 32'h0,         2'b11, "above"};
        vecs[3] = '{32'h8000_0002, 32'h0,         2'b10, "misalign"};
        vecs[4] = '{32'h7FFF_FFFC, 32'h0,         2'b11, "below"};
        vecs[5] = '{32'h8000_0FFC, 32'h5A5A_0FFC, 2'b00, "lastword"};
        vecs[6] = '{32'h8000_0FFF, 32'h0,         2'b10, "lastmis"};
        expb[0] = 32'hDEAD_BEEF; expb[1] = 32'h11BB_33DD;
        expb[2] = 32'h2222_2222; expb[3] = 32'h3232_3232;

        sel = 1'b0; arvalid = 1'b0; rready = 1'b1; araddr = 32'h0;
        wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0; wr_mask = 4'h0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset arready", 64'({arready_a, arready_b}), 64'b00);
        chk("reset rvalid", 64'({rvalid_a, rvalid_b}), 64'b00);
        reset = 1'b0;
        @(negedge clock);
        chk("post reset arready", 64'({arready_a, arready_b}), 64'b11);
        chk("post reset rdata", 64'({rdata_a, rresp_a}), 64'h0);

        write_word(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
        write_word(32'h8000_0004, 32'h1122_3344, 4'hF);
        write_word(32'h8000_0004, 32'hAABB_CCDD, 4'b0101);
        write_word(32'h8000_0008, 32'h2222_2222, 4'hF);
        write_word(32'h8000_000C, 32'h3030_3030, 4'hF);
        write_word(32'h8000_0FFC, 32'h5A5A_0FFC, 4'hF);
        write_word(32'h8000_1000, 32'hFFFF_FFFF, 4'hF);
        write_word(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF);

        for (int i = 0; i < 7; i++)
            do_read(1'b0, vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].name);

        // Write during WAIT is visible; write on the capture edge is not.
        sel = 1'b0; arvalid = 1'b1; araddr = 32'h8000_000C;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        wr_en = 1'b1; wr_addr = 32'h8000_000C; wr_data = 32'h3131_3131; wr_mask = 4'hF;
        @(negedge clock);
        wr_en = 1'b0;
        @(negedge clock);
        wr_en = 1'b1; wr_data = 32'h3232_3232;
        @(negedge clock);
        wr_en = 1'b0;
        chk("wait write rvalid", 64'(rvalid_a), 64'd1);
        chk("wait write rdata", 64'(rdata_a), 64'h3131_3131);
        @(negedge clock);
        chk("wait write done", 64'(rvalid_a), 64'd0);
        do_read(1'b0, 32'h8000_000C, 32'h3232_3232, 2'b00, "capture edge write");

        // Stall in RESP with a second request held pending.
        rready = 1'b0; arvalid = 1'b1; araddr = 32'h8000_0000;
        @(posedge clock);
        @(negedge clock);
        for (int t = 0; t < 20 && !rvalid_a; t++) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            chk("stall", 64'({rvalid_a, arready_a, rresp_a, rdata_a}), {30'h0, 1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF});
            @(negedge clock);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clock);
        chk("stall release", 64'({rvalid_a, arready_a}), 64'b01);

        // Reset during WAIT discards the request.
        arvalid = 1'b1; araddr = 32'h8000_0000;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid reset", 64'({rvalid_a, arready_a}), 64'b00);
        @(negedge clock);
        chk("mid reset arready", 64'(arready_a), 64'd1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (rvalid_a) seen++;
            @(negedge clock);
        end
        chk("no beat after reset", 64'(seen), 64'd0);
        do_read(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00, "survives reset");

        // Zero-latency build, back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            do_read(1'b1, 32'h8000_0000 + 32'(4 * i), expb[i], 2'b00, "lat0");
            hs[i] = last_hs;
        end
        for (int i = 1; i < 4; i++)
            chk("lat0 spacing", 64'(hs[i] - hs[i-1]), 64'd3);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/ysyx_23060059_imem_responder.md
# ysyx_23060059_imem_responder

AXI4-Lite read-channel responder (slave) backing the instruction fetch path: accepts single-beat AR requests from the icache miss port, waits a fixed access latency, and returns one 32-bit word on the R channel with an OKAY/SLVERR/DECERR response. It holds a word-addressed memory array with a side write port for preload and self-modifying-code tests. It sits behind the icache in simulation and in the tile-level bench as the instruction memory model.

## Interface
- BASE, 32'h8000_0000, byte address of word 0
- DEPTH_LOG2, 10, log2 of word count (default 1024 words = 4 KB)
- LATENCY, 2, extra wait cycles between AR handshake and R valid; legal 0..15
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_araddr  in  32  read byte address
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready
- axi_rdata  out  32  read data
- axi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- wr_en  in  1  preload write enable
- wr_addr  in  32  preload byte address; bits [1:0] ignored
- wr_data  in  32  preload data
- wr_mask  in  4  byte enables, bit i writes wr_data[8i+7:8i]

## Operation
- States: IDLE, WAIT, RESP; one outstanding transaction, no overlap.
- IDLE: axi_arready=1. On arvalid&&arready: latch araddr, load cnt=LATENCY, go WAIT.
- WAIT: axi_arready=0. If cnt==0 go RESP, else cnt-=1. cnt is 4 bits.
- Entry to RESP: register rdata/rresp from latched address and array contents as of before that edge.
- Decode: off = addr-BASE (32-bit wrapping subtract). off >= 4<<DEPTH_LOG2 → DECERR, rdata=0. Else addr[1:0]!=0 → SLVERR, rdata=0. Else OKAY, rdata=mem[off>>2]. DECERR has priority.
- RESP: axi_rvalid=1, rdata/rresp held stable until rready. On rvalid&&rready go IDLE.
- Write port: independent of FSM, every cycle; if wr_en and wr_addr in range, mem[(wr_addr-BASE)>>2] updated per wr_mask; out-of-range writes dropped silently.
- Write and read-capture on same edge to same word: capture returns old data. Writes during WAIT that commit before the RESP-entry edge are visible.
- Memory array is not reset; contents survive reset.

## Timing
- Reset values: axi_arready=0 while reset high, 1 first cycle after; axi_rvalid=0, axi_rdata=0, axi_rresp=00, state=IDLE, cnt=0.
- AR handshake at edge E0 → axi_rvalid rises after edge E0+LATENCY+1 (LATENCY=0: one cycle later).
- R handshake at edge Ek → rvalid low and arready high in the following cycle; next AR can handshake at Ek+1. Minimum AR-to-AR spacing LATENCY+3 cycles with rready held high.
- arvalid in WAIT/RESP ignored (arready=0); master must hold it per AXI.
- rready low in RESP: stall indefinitely, outputs unchanged.
- rdata/rresp keep last value after RESP; only rvalid qualifies them.
- Reset mid-WAIT or mid-RESP: next cycle IDLE, rvalid=0, transaction discarded, no R beat issued.

## Test plan
- Preload mem[0]=32'hDEAD_BEEF via wr_en, mask 4'hF; AR 32'h8000_0000 at E0, rready=1, LATENCY=2 → rvalid high after E3, rdata=DEAD_BEEF, rresp=00, arready high after E4.
- Masked write: preload word 1 = 32'h1122_3344, then write 32'hAABB_CCDD mask 4'b0101 → read 32'h8000_0004 returns 32'h11BB_33DD.
- AR 32'h8000_1000 → rresp=11, rdata=0; AR 32'h8000_0002 → rresp=10, rdata=0; AR 32'h7FFF_FFFC → rresp=11.
- Hold rready=0 for 5 cycles in RESP → rvalid, rdata, rresp constant; arvalid asserted meanwhile sees arready=0; single beat on rready.
- LATENCY=0 build: AR at E0 → rvalid after E1; back-to-back reads of 4 consecutive words with rready=1 each complete in 3 cycles.
- Assert reset during WAIT → no rvalid ever for that request, arready=1 one cycle after reset release, preloaded data still readable.
